// File: rtl/conv2d_stream_pkg.sv
// Shared state encoding and elaboration-time size helpers for the streaming 2-D convolution engine.
package conv2d_stream_pkg;

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits for single-entry arrays.
    function automatic int addr_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int out_dim(input int size, input int pad, input int k, input int stride);
        return (size + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/conv2d_mac.sv
// Accumulator with clear-to-bias, signed multiply-add and shift/saturate output register.
// CONV2D_STREAM_RELU_EN defined: negative saturated results are forced to zero.
module conv2d_mac #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 22,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              last,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] out_data
);

    localparam int PW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] acc, sum, bias_ext, prod_ext;
    logic signed [PW-1:0]    x_ext, w_ext, prod;

    function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0]  s;
        logic signed [DATA_W-1:0] r;
        s = v >>> OUT_SHIFT;
        if (s > MAX_V)
            r = MAX_V[DATA_W-1:0];
        else if (s < MIN_V)
            r = MIN_V[DATA_W-1:0];
        else
            r = s[DATA_W-1:0];
`ifdef CONV2D_STREAM_RELU_EN
        if (r[DATA_W-1])
            r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
        w_ext    = {{DATA_W{w[DATA_W-1]}}, w};
        prod     = x_ext * w_ext;
        prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
        bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
        sum      = acc + prod_ext;
    end

    // The final product is folded in on the same edge the result is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (clear)
                acc <= bias_ext;
            else if (en)
                acc <= sum;
            if (en && last)
                out_data <= shift_sat(sum);
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Frame-buffered 2-D convolution with a single time-multiplexed MAC and valid/ready streams.
// CONV2D_STREAM_RELU_EN (see conv2d_mac) clamps negative outputs to zero.
module conv2d_stream import conv2d_stream_pkg::*; #(
    parameter int IN_CH     = 1,
    parameter int OUT_CH    = 1,
    parameter int ROWS      = 28,
    parameter int COLS      = 28,
    parameter int K_R       = 3,
    parameter int K_C       = 3,
    parameter int STRIDE_R  = 1,
    parameter int STRIDE_C  = 1,
    parameter int PAD_R     = 0,
    parameter int PAD_C     = 0,
    parameter int DATA_W    = 8,
    parameter int OUT_SHIFT = 0,
    localparam int WA_W     = addr_w(OUT_CH * IN_CH * K_R * K_C),
    localparam int BA_W     = addr_w(OUT_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              w_we,
    input  logic [WA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              b_we,
    input  logic [BA_W-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int OUT_R = out_dim(ROWS, PAD_R, K_R, STRIDE_R);
    localparam int OUT_C = out_dim(COLS, PAD_C, K_C, STRIDE_C);
    localparam int N     = IN_CH * K_R * K_C;
    localparam int ACC_W = acc_width(DATA_W, N);
    localparam int FB    = IN_CH * ROWS * COLS;
    localparam int WN    = OUT_CH * N;
    localparam int FB_W  = addr_w(FB);
    localparam int OR_W  = addr_w(OUT_R);
    localparam int OC_W  = addr_w(OUT_C);
    localparam int CI_W  = addr_w(IN_CH);
    localparam int KR_W  = addr_w(K_R);
    localparam int KC_W  = addr_w(K_C);

    localparam logic [FB_W-1:0] LC_LAST = FB_W'(FB - 1);
    localparam logic [BA_W-1:0] CO_LAST = BA_W'(OUT_CH - 1);
    localparam logic [OR_W-1:0] OR_LAST = OR_W'(OUT_R - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_C - 1);
    localparam logic [CI_W-1:0] CI_LAST = CI_W'(IN_CH - 1);
    localparam logic [KR_W-1:0] KR_LAST = KR_W'(K_R - 1);
    localparam logic [KC_W-1:0] KC_LAST = KC_W'(K_C - 1);

    state_t state, state_next;

    logic [FB_W-1:0] load_cnt, x_addr;
    logic [BA_W-1:0] co, bias_co;
    logic [OR_W-1:0] orow;
    logic [OC_W-1:0] ocol;
    logic [CI_W-1:0] ci;
    logic [KR_W-1:0] kr;
    logic [KC_W-1:0] kc;
    logic [WA_W-1:0] w_idx;
    logic            accept, load_last, mac_last, out_last, hs, mac_clear, mac_en;
    logic [DATA_W-1:0] x_val;
    int              pr, pc;

    logic [DATA_W-1:0] fbuf  [FB];
    logic [DATA_W-1:0] w_mem [WN];
    logic [DATA_W-1:0] b_mem [OUT_CH];

    always_comb begin
        accept    = (state == LOAD) && in_valid;
        load_last = (load_cnt == LC_LAST);
        mac_last  = (ci == CI_LAST) && (kr == KR_LAST) && (kc == KC_LAST);
        out_last  = (co == CO_LAST) && (orow == OR_LAST) && (ocol == OC_LAST);
        hs        = (state == EMIT) && out_ready;
        mac_en    = (state == MAC);
        mac_clear = (accept && load_last) || (hs && !out_last);
        bias_co   = '0;
        if (hs && !out_last && orow == OR_LAST && ocol == OC_LAST)
            bias_co = co + BA_W'(1);
        else if (hs)
            bias_co = co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_last)
                    state_next = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (mac_last)
                    state_next = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_next = out_last ? LOAD : MAC;
            end
            default: state_next = LOAD;
        endcase
    end

    // Kernel counters wrap to zero on the last product, so they are ready for the next output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            co         <= '0;
            orow       <= '0;
            ocol       <= '0;
            ci         <= '0;
            kr         <= '0;
            kc         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs && out_last;
            case (state)
                LOAD: if (in_valid) load_cnt <= load_last ? '0 : load_cnt + FB_W'(1);
                MAC: begin
                    if (kc == KC_LAST) begin
                        kc <= '0;
                        if (kr == KR_LAST) begin
                            kr <= '0;
                            ci <= (ci == CI_LAST) ? '0 : ci + CI_W'(1);
                        end else begin
                            kr <= kr + KR_W'(1);
                        end
                    end else begin
                        kc <= kc + KC_W'(1);
                    end
                end
                EMIT: if (out_ready) begin
                    if (ocol == OC_LAST) begin
                        ocol <= '0;
                        if (orow == OR_LAST) begin
                            orow <= '0;
                            co   <= (co == CO_LAST) ? '0 : co + BA_W'(1);
                        end else begin
                            orow <= orow + OR_W'(1);
                        end
                    end else begin
                        ocol <= ocol + OC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            fbuf[load_cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WN; i++)
                w_mem[i] <= '0;
            for (int i = 0; i < OUT_CH; i++)
                b_mem[i] <= '0;
        end else if (state == LOAD) begin
            if (w_we && int'(w_addr) < WN)
                w_mem[w_addr] <= w_data;
            if (b_we && int'(b_addr) < OUT_CH)
                b_mem[b_addr] <= b_data;
        end
    end

    // Padded coordinates outside the stored image read as zero.
    always_comb begin
        pr     = int'(orow) * STRIDE_R + int'(kr) - PAD_R;
        pc     = int'(ocol) * STRIDE_C + int'(kc) - PAD_C;
        x_addr = '0;
        x_val  = '0;
        if (pr >= 0 && pr < ROWS && pc >= 0 && pc < COLS) begin
            x_addr = FB_W'((int'(ci) * ROWS + pr) * COLS + pc);
            x_val  = fbuf[x_addr];
        end
        w_idx = WA_W'(((int'(co) * IN_CH + int'(ci)) * K_R + int'(kr)) * K_C + int'(kc));
    end

    conv2d_mac #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (mac_clear),
        .en      (mac_en),
        .last    (mac_last),
        .bias    (b_mem[bias_co]),
        .x       (x_val),
        .w       (w_mem[w_idx]),
        .out_data(out_data)
    );

endmodule
